wu_mem_read_buffer: RTL and testbench

- Sits directly downstream of the WU fetch stage. Holds the WU instruction memory array and services the fetch stage's address/read stream.
- Buffers the returned instructions in a small FIFO for the WU decoder, and back-pressures fetch through `wum__wuf__stall`.
- Sized so that fetch's registered stall path and registered read path never overflow the FIFO.
- Also provides a system-side write port for loading the WU program.

---
 rtl/wu_mem_read_buffer_pkg.sv | 15 +
 rtl/wu_mem_fifo.sv | 57 +++++
 rtl/wu_mem_read_buffer.sv | 120 ++++++++++++
 tb/tb_wu_mem_read_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wu_mem_read_buffer_pkg.sv
// Shared defaults for the WU instruction memory read buffer and its output FIFO.
package wu_mem_read_buffer_pkg;

  localparam int WUM_ADDR_WIDTH      = 10;
  localparam int WUM_DATA_WIDTH      = 64;
  localparam int WUM_FIFO_DEPTH      = 8;
  localparam int WUM_SKID            = 4;
  localparam int WUM_STALL_THRESHOLD = WUM_FIFO_DEPTH - WUM_SKID;

  // A FIFO entry carries the instruction word with its source address.
  function automatic int wum_entry_width(input int data_width, input int addr_width);
    return data_width + addr_width;
  endfunction

endpackage

// File: rtl/wu_mem_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push while full is accepted only alongside a pop.
module wu_mem_fifo
  import wu_mem_read_buffer_pkg::*;
#(
  parameter int WIDTH = 74,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW:0]      wr_ptr_r;
  logic [PW:0]      rd_ptr_r;
  logic             pop_s;
  logic             push_s;

  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign full   = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign count  = wr_ptr_r - rd_ptr_r;
  assign rdata  = mem_r[rd_ptr_r[PW-1:0]];
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);

  // Pointer and storage update; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[PW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + (PW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wu_mem_read_buffer.sv
// WU instruction memory with a two-stage read pipeline feeding a decoder FIFO,
// registered stall back-pressure toward fetch and a system-side program-load port.
module wu_mem_read_buffer
  import wu_mem_read_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = WUM_ADDR_WIDTH,
  parameter int DATA_WIDTH = WUM_DATA_WIDTH,
  parameter int FIFO_DEPTH = WUM_FIFO_DEPTH,
  parameter int SKID       = WUM_SKID
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  wuf__wum__read,
  input  logic [ADDR_WIDTH-1:0] wuf__wum__addr,
  output logic                  wum__wuf__stall,
  input  logic                  sys__wum__write,
  input  logic [ADDR_WIDTH-1:0] sys__wum__addr,
  input  logic [DATA_WIDTH-1:0] sys__wum__data,
  input  logic                  mcntl__wum__flush,
  output logic                  wum__wud__valid,
  output logic [DATA_WIDTH-1:0] wum__wud__instr,
  output logic [ADDR_WIDTH-1:0] wum__wud__addr,
  input  logic                  wud__wum__ready,
  output logic                  wum__mcntl__overflow
);

  localparam int ENTRY_W   = wum_entry_width(DATA_WIDTH, ADDR_WIDTH);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int THRESHOLD = FIFO_DEPTH - SKID;

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
  logic                  rd_vld_p1_r;
  logic [DATA_WIDTH-1:0] rd_data_p1_r;
  logic [ADDR_WIDTH-1:0] rd_addr_p1_r;
  logic                  stall_r;
  logic                  overflow_r;

  logic [ENTRY_W-1:0]    head_s;
  logic                  full_s;
  logic                  empty_s;
  logic [CW-1:0]         count_s;
  logic                  pop_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic                  rd_vld_next_s;
  logic [CW-1:0]         count_next_s;
  logic [CW:0]           occupancy_s;

  // Program load; no reset so the array can become an SRAM macro.
  always_ff @(posedge clk) begin
    if (sys__wum__write) begin
      mem_r[sys__wum__addr] <= sys__wum__data;
    end
  end

  // Stage R: nonblocking capture gives read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      rd_vld_p1_r  <= 1'b0;
      rd_data_p1_r <= '0;
      rd_addr_p1_r <= '0;
    end else begin
      rd_vld_p1_r <= rd_vld_next_s;
      if (wuf__wum__read) begin
        rd_data_p1_r <= mem_r[wuf__wum__addr];
        rd_addr_p1_r <= wuf__wum__addr;
      end
    end
  end

  wu_mem_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset_poweron),
    .flush (mcntl__wum__flush),
    .push  (rd_vld_p1_r),
    .pop   (pop_s),
    .wdata ({rd_data_p1_r, rd_addr_p1_r}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Occupancy the FIFO and stage R will hold after this edge.
  always_comb begin
    pop_s         = !empty_s && wud__wum__ready;
    push_ok_s     = rd_vld_p1_r && (!full_s || pop_s);
    drop_s        = rd_vld_p1_r && full_s && !pop_s;
    rd_vld_next_s = wuf__wum__read && !mcntl__wum__flush;
    if (mcntl__wum__flush) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_s + CW'(push_ok_s) - CW'(pop_s);
    end
    occupancy_s = {1'b0, count_next_s} + (CW+1)'(rd_vld_next_s);
  end

  // Registered stall and sticky overflow; flush suppresses any drop on its edge.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      stall_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      stall_r <= (occupancy_s >= (CW+1)'(THRESHOLD));
      if (drop_s && !mcntl__wum__flush) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign wum__wuf__stall      = stall_r;
  assign wum__mcntl__overflow = overflow_r;
  assign wum__wud__valid      = !empty_s;
  assign wum__wud__instr      = head_s[ENTRY_W-1:ADDR_WIDTH];
  assign wum__wud__addr       = head_s[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_wu_mem_read_buffer.sv
// Directed bench for wu_mem_read_buffer: a streaming vector table plus hand-written
// sequences for back-pressure, skid violation, flush, collisions and reset.
module tb_wu_mem_read_buffer;

  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_poweron;
  logic          read;
  logic [AW-1:0] raddr;
  logic          stall;
  logic          swrite;
  logic [AW-1:0] saddr;
  logic [DW-1:0] sdata;
  logic          flush;
  logic          valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] oaddr;
  logic          ready;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_mem [32];

  typedef struct {
    logic          rd;
    logic [AW-1:0] a;
    logic          rdy;
    logic          e_vld;
    logic [AW-1:0] e_addr;
    logic          e_stall;
  } vec_t;
  vec_t vt [18];

  wu_mem_read_buffer dut (
    .clk                  (clk),
    .reset_poweron        (reset_poweron),
    .wuf__wum__read       (read),
    .wuf__wum__addr       (raddr),
    .wum__wuf__stall      (stall),
    .sys__wum__write      (swrite),
    .sys__wum__addr       (saddr),
    .sys__wum__data       (sdata),
    .mcntl__wum__flush    (flush),
    .wum__wud__valid      (valid),
    .wum__wud__instr      (instr),
    .wum__wud__addr       (oaddr),
    .wud__wum__ready      (ready),
    .wum__mcntl__overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sys_write(input int a, input logic [DW-1:0] d);
    swrite = 1'b1;
    saddr  = AW'(a);
    sdata  = d;
    exp_mem[a] = d;
    tick();
    swrite = 1'b0;
  endtask

  task automatic check_head(input string name, input int a);
    chk({name, "_valid"}, 64'(valid), 64'd1);
    chk({name, "_addr"}, 64'(oaddr), 64'(a));
    chk({name, "_instr"}, instr, exp_mem[a]);
  endtask

  initial begin
    reset_poweron = 1'b1;
    read = 1'b0; raddr = '0; swrite = 1'b0; saddr = '0; sdata = '0;
    flush = 1'b0; ready = 1'b0;
    tick();
    tick();
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_instr", instr, 64'd0);
    chk("rst_addr", 64'(oaddr), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset_poweron = 1'b0;

    for (int a = 0; a < 32; a++) begin
      sys_write(a, 64'hA5A5_0000_0000_0000 + 64'(a) * 64'h0000_0001_0000_0101);
    end

    // Load and single read: valid two edges after the read.
    sys_write(5, 64'h0000_0000_0000_1111);
    read = 1'b1; raddr = 10'd5;
    tick();
    read = 1'b0;
    chk("single_lat1_valid", 64'(valid), 64'd0);
    tick();
    check_head("single", 5);
    chk("single_instr_const", instr, 64'h0000_0000_0000_1111);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("single_popped", 64'(valid), 64'd0);

    // Streaming table: read at vector k appears at vector k+1 with ready held high.
    for (int k = 0; k < 18; k++) begin
      vt[k].rd      = (k < 16);
      vt[k].a       = (k < 16) ? AW'(k) : '0;
      vt[k].rdy     = 1'b1;
      vt[k].e_vld   = (k >= 1) && (k <= 16);
      vt[k].e_addr  = (k >= 1) ? AW'(k - 1) : '0;
      vt[k].e_stall = 1'b0;
    end
    for (int k = 0; k < 18; k++) begin
      read = vt[k].rd; raddr = vt[k].a; ready = vt[k].rdy;
      tick();
      chk($sformatf("stream%0d_valid", k), 64'(valid), 64'(vt[k].e_vld));
      chk($sformatf("stream%0d_stall", k), 64'(stall), 64'(vt[k].e_stall));
      if (vt[k].e_vld) begin
        chk($sformatf("stream%0d_addr", k), 64'(oaddr), 64'(vt[k].e_addr));
        chk($sformatf("stream%0d_instr", k), instr, exp_mem[vt[k].e_addr]);
      end
    end
    read = 1'b0; ready = 1'b0;
    chk("stream_overflow", 64'(overflow), 64'd0);

    // Back-pressure: stall rises after the fourth read, four more reads fill to 8.
    for (int i = 0; i < 8; i++) begin
      read = 1'b1; raddr = AW'(16 + i);
      tick();
      chk($sformatf("bp_stall%0d", i), 64'(stall), (i >= 3) ? 64'd1 : 64'd0);
    end
    read = 1'b0;
    tick();
    chk("bp_full_stall", 64'(stall), 64'd1);
    chk("bp_overflow", 64'(overflow), 64'd0);
    ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check_head($sformatf("bp_drain%0d", j), 16 + j);
      tick();
    end
    ready = 1'b0;
    chk("bp_drained_valid", 64'(valid), 64'd0);
    chk("bp_drained_stall", 64'(stall), 64'd0);

    // Flush: five buffered words, one in flight, one read on the flush edge.
    for (int i = 0; i < 6; i++) begin
      read = 1'b1; raddr = AW'(20 + i);
      tick();
    end
    chk("fl_pre_valid", 64'(valid), 64'd1);
    chk("fl_pre_stall", 64'(stall), 64'd1);
    flush = 1'b1; read = 1'b1; raddr = 10'd26;
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(valid), 64'd0);
    chk("fl_stall", 64'(stall), 64'd0);
    chk("fl_overflow", 64'(overflow), 64'd0);
    read = 1'b1; raddr = 10'd7;
    tick();
    read = 1'b0;
    chk("fl_inflight_gone", 64'(valid), 64'd0);
    tick();
    check_head("fl_after", 7);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("fl_after_popped", 64'(valid), 64'd0);

    // Skid violation: ten reads with ready low keep exactly the first eight.
    for (int i = 0; i < 10; i++) begin
      read = 1'b1; raddr = AW'(i);
      tick();
    end
    read = 1'b0;
    tick();
    tick();
    chk("skid_overflow", 64'(overflow), 64'd1);
    ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check_head($sformatf("skid_keep%0d", j), j);
      tick();
    end
    ready = 1'b0;
    chk("skid_only8", 64'(valid), 64'd0);
    chk("skid_sticky", 64'(overflow), 64'd1);

    // Collision: same-edge write of 0xAA and read of addr 3 returns the old 0x55.
    sys_write(3, 64'h55);
    swrite = 1'b1; saddr = 10'd3; sdata = 64'hAA;
    read = 1'b1; raddr = 10'd3;
    tick();
    swrite = 1'b0; read = 1'b0;
    tick();
    chk("coll_old_valid", 64'(valid), 64'd1);
    chk("coll_old_instr", instr, 64'h55);
    ready = 1'b1; read = 1'b1; raddr = 10'd3;
    tick();
    read = 1'b0; ready = 1'b0;
    chk("coll_gap_valid", 64'(valid), 64'd0);
    tick();
    chk("coll_new_valid", 64'(valid), 64'd1);
    chk("coll_new_instr", instr, 64'hAA);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // Reset mid-stream with stall and overflow both set.
    for (int i = 0; i < 4; i++) begin
      read = 1'b1; raddr = AW'(10 + i);
      tick();
    end
    chk("mid_pre_stall", 64'(stall), 64'd1);
    chk("mid_pre_overflow", 64'(overflow), 64'd1);
    reset_poweron = 1'b1;
    tick();
    reset_poweron = 1'b0; read = 1'b0;
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_instr", instr, 64'd0);
    chk("mid_rst_addr", 64'(oaddr), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    tick();
    tick();
    chk("mid_rst_no_late", 64'(valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
